// File: rtl/score_digits_renderer.sv
// BCD score accumulator with a once-per-frame snapshot, drawn as a clipped text overlay
// through a two-stage registered font pipeline (pixel in -> rgb/on two cycles later).
module score_digits_renderer #(
    parameter int         NUM_DIGITS   = 6,
    parameter int         DIGIT_W      = 8,
    parameter int         DIGIT_H      = 12,
    parameter logic [2:0] FG_COLOR     = 3'b111,
    parameter bit         LZ_SUPPRESS  = 1'b1,
    parameter int         BLINK_FRAMES = 16
) (
    input  logic                    pclk,
    input  logic                    rst,
    input  logic [9:0]              pixel_x,
    input  logic [9:0]              pixel_y,
    input  logic [9:0]              xcoord_ini,
    input  logic [9:0]              ycoord_ini,
    input  logic                    frame_tick,
    input  logic                    clear,
    input  logic                    add_valid,
    input  logic [3:0]              add_value,
    output logic                    add_ready,
    output logic [4*NUM_DIGITS-1:0] score_bcd,
    output logic                    saturated,
    output logic [2:0]              rgb,
    output logic                    on
);
    localparam int          DW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int          CW    = (DIGIT_W > 1) ? $clog2(DIGIT_W) : 1;
    localparam int          BW    = $clog2(BLINK_FRAMES + 1);
    localparam logic [10:0] BOX_W = 11'(NUM_DIGITS * DIGIT_W);
    localparam logic [10:0] BOX_H = 11'(DIGIT_H);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t                  state_q, state_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [3:0]              cin_q, cin_d;
    logic [DW-1:0]           d_q, d_d;
    logic                    sat_q, sat_d;
    logic [3:0]              cur_digit;
    logic [4:0]              sum;

    always_comb begin
        // NOTE: every signal written here is defaulted first, so no path can infer a latch.
        state_d   = state_q;
        digits_d  = digits_q;
        cin_d     = cin_q;
        d_d       = d_q;
        sat_d     = sat_q;
        cur_digit = digits_q[{d_q, 2'b00} +: 4];
        sum       = {1'b0, cur_digit} + {1'b0, cin_q};
        if (clear) begin
            state_d  = IDLE;
            digits_d = '0;
            sat_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (add_valid) begin
                    cin_d   = (add_value > 4'd9) ? 4'd9 : add_value;
                    d_d     = '0;
                    state_d = ADD;
                end
                ADD: begin
                    if (sum >= 5'd10) begin
                        digits_d[{d_q, 2'b00} +: 4] = 4'(sum - 5'd10);
                        cin_d = 4'd1;
                    end else begin
                        digits_d[{d_q, 2'b00} +: 4] = sum[3:0];
                        cin_d = 4'd0;
                    end
                    if (sum < 5'd10 || d_q == DW'(NUM_DIGITS - 1)) state_d = DONE;
                    else                                           d_d = d_q + 1'b1;
                end
                DONE: begin
                    // A carry surviving the top digit means overflow: clamp to all nines.
                    if (cin_q != 4'd0) begin
                        digits_d = {NUM_DIGITS{4'h9}};
                        sat_d    = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state is only ever updated with non-blocking assignments.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q  <= IDLE;
            digits_q <= '0;
            cin_q    <= '0;
            d_q      <= '0;
            sat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            digits_q <= digits_d;
            cin_q    <= cin_d;
            d_q      <= d_d;
            sat_q    <= sat_d;
        end
    end

    assign add_ready = (state_q == IDLE);
    assign score_bcd = digits_q;
    assign saturated = sat_q;

    logic [4*NUM_DIGITS-1:0] shown_q;
    logic [BW-1:0]           blink_cnt_q;
    logic                    visible_q;

    always_ff @(posedge pclk) begin
        if (rst) begin
            shown_q     <= '0;
            blink_cnt_q <= '0;
            visible_q   <= 1'b1;
        end else begin
            if (frame_tick) shown_q <= digits_q;
            if (!sat_q) begin
                blink_cnt_q <= '0;
                visible_q   <= 1'b1;
            end else if (frame_tick) begin
                if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
                    blink_cnt_q <= '0;
                    visible_q   <= ~visible_q;
                end else begin
                    blink_cnt_q <= blink_cnt_q + 1'b1;
                end
            end
        end
    end

    // 8x12 base font, row 0 in the top byte, MSB = leftmost column; other sizes are resampled.
    function automatic logic [DIGIT_W-1:0] glyph_row(input logic [3:0] dig, input logic [9:0] r);
        logic [95:0] g;
        logic [7:0]  base;
        int          sr;
        case (dig)
            4'd0:    g = 96'h003C666666666666663C0000;
            4'd1:    g = 96'h0018381818181818187E0000;
            4'd2:    g = 96'h003C66060C183060607E0000;
            4'd3:    g = 96'h003C66061C060606663C0000;
            4'd4:    g = 96'h000C1C3C6CCCFE0C0C0C0000;
            4'd5:    g = 96'h007E60607C060606663C0000;
            4'd6:    g = 96'h003C66607C666666663C0000;
            4'd7:    g = 96'h007E06060C18183030300000;
            4'd8:    g = 96'h003C66663C666666663C0000;
            4'd9:    g = 96'h003C6666663E0606663C0000;
            default: g = '0;
        endcase
        sr   = (int'(r) * 12) / DIGIT_H;
        base = (sr < 12) ? 8'(g >> (8 * (11 - sr))) : 8'h00;
        glyph_row = '0;
        for (int c = 0; c < DIGIT_W; c++) glyph_row[DIGIT_W-1-c] = base[7 - (c * 8) / DIGIT_W];
    endfunction

    logic [9:0]    rx, ry, slot;
    logic [CW-1:0] col;
    logic          inbox, slot_blank, zeros_above;
    logic [3:0]    slot_digit;

    always_comb begin
        rx    = pixel_x - xcoord_ini;
        ry    = pixel_y - ycoord_ini;
        // 11-bit bounds so an overlay hanging past column 1023 clips instead of wrapping.
        inbox = ({1'b0, pixel_x} >= {1'b0, xcoord_ini}) && ({1'b0, pixel_x} < {1'b0, xcoord_ini} + BOX_W)
             && ({1'b0, pixel_y} >= {1'b0, ycoord_ini}) && ({1'b0, pixel_y} < {1'b0, ycoord_ini} + BOX_H);
        slot  = 10'(rx / DIGIT_W);
        col   = CW'(rx % DIGIT_W);
        slot_digit  = '0;
        slot_blank  = 1'b0;
        zeros_above = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            zeros_above = zeros_above && (shown_q[4*(NUM_DIGITS-1-k) +: 4] == 4'd0);
            if (slot == 10'(k)) begin
                slot_digit = shown_q[4*(NUM_DIGITS-1-k) +: 4];
                slot_blank = LZ_SUPPRESS && (k != NUM_DIGITS - 1) && zeros_above;
            end
        end
    end

    logic               inbox_q, blank_q, on_q;
    logic [CW-1:0]      col_q, bit_idx;
    logic [DIGIT_W-1:0] row_q;
    logic [2:0]         rgb_q;
    logic               pix_on;

    assign bit_idx = CW'(DIGIT_W - 1) - col_q;
    assign pix_on  = inbox_q && !blank_q && visible_q && row_q[bit_idx];

    always_ff @(posedge pclk) begin
        if (rst) begin
            inbox_q <= 1'b0;
            blank_q <= 1'b0;
            col_q   <= '0;
            row_q   <= '0;
            on_q    <= 1'b0;
            rgb_q   <= 3'b000;
        end else begin
            inbox_q <= inbox;
            blank_q <= slot_blank;
            col_q   <= col;
            row_q   <= glyph_row(slot_digit, ry);
            on_q    <= pix_on;
            rgb_q   <= pix_on ? FG_COLOR : 3'b000;
        end
    end

    assign on  = on_q;
    assign rgb = rgb_q;
endmodule

// File: tb/tb_score_digits_renderer.sv
// Self-checking bench for score_digits_renderer: decimal score model plus a font-table pixel model.
module tb_score_digits_renderer;
    localparam int N     = 4;
    localparam int W     = 8;
    localparam int H     = 12;
    localparam int BLINK = 16;

    localparam logic [7:0] FONT [10][12] = '{
        '{8'h00, 8'h3C, 8'h66, 8'h66, 8'h66, 8'h66, 8'h66, 8'h66, 8'h66, 8'h3C, 8'h00, 8'h00},
        '{8'h00, 8'h18, 8'h38, 8'h18, 8'h18, 8'h18, 8'h18, 8'h18, 8'h18, 8'h7E, 8'h00, 8'h00},
        '{8'h00, 8'h3C, 8'h66, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'h60, 8'h7E, 8'h00, 8'h00},
        '{8'h00, 8'h3C, 8'h66, 8'h06, 8'h1C, 8'h06, 8'h06, 8'h06, 8'h66, 8'h3C, 8'h00, 8'h00},
        '{8'h00, 8'h0C, 8'h1C, 8'h3C, 8'h6C, 8'hCC, 8'hFE, 8'h0C, 8'h0C, 8'h0C, 8'h00, 8'h00},
        '{8'h00, 8'h7E, 8'h60, 8'h60, 8'h7C, 8'h06, 8'h06, 8'h06, 8'h66, 8'h3C, 8'h00, 8'h00},
        '{8'h00, 8'h3C, 8'h66, 8'h60, 8'h7C, 8'h66, 8'h66, 8'h66, 8'h66, 8'h3C, 8'h00, 8'h00},
        '{8'h00, 8'h7E, 8'h06, 8'h06, 8'h0C, 8'h18, 8'h18, 8'h30, 8'h30, 8'h30, 8'h00, 8'h00},
        '{8'h00, 8'h3C, 8'h66, 8'h66, 8'h3C, 8'h66, 8'h66, 8'h66, 8'h66, 8'h3C, 8'h00, 8'h00},
        '{8'h00, 8'h3C, 8'h66, 8'h66, 8'h66, 8'h3E, 8'h06, 8'h06, 8'h66, 8'h3C, 8'h00, 8'h00}
    };

    typedef struct {
        int x;
        int y;
        bit e;
    } pix_t;

    logic           pclk = 1'b0;
    logic           rst, frame_tick, clear, add_valid;
    logic [9:0]     pixel_x, pixel_y, xcoord_ini, ycoord_ini;
    logic [3:0]     add_value;
    logic           add_ready, saturated, on;
    logic [4*N-1:0] score_bcd;
    logic [2:0]     rgb;

    int total = 0;
    int bad   = 0;
    int score_m, shown_m, sat_frames, ox, oy;
    bit sat_m;

    score_digits_renderer #(
        .NUM_DIGITS(N), .DIGIT_W(W), .DIGIT_H(H), .FG_COLOR(3'b111),
        .LZ_SUPPRESS(1'b1), .BLINK_FRAMES(BLINK)
    ) dut (
        .pclk(pclk), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .xcoord_ini(xcoord_ini), .ycoord_ini(ycoord_ini), .frame_tick(frame_tick),
        .clear(clear), .add_valid(add_valid), .add_value(add_value), .add_ready(add_ready),
        .score_bcd(score_bcd), .saturated(saturated), .rgb(rgb), .on(on)
    );

    always #5 pclk = ~pclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=time_limit_reached expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pow10(input int e);
        int p = 1;
        for (int i = 0; i < e; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] b = '0;
        for (int i = 0; i < N; i++) b[4*i +: 4] = 4'((v / pow10(i)) % 10);
        return b;
    endfunction

    function automatic bit visible_m();
        return !sat_m || ((sat_frames / BLINK) % 2 == 0);
    endfunction

    function automatic bit model_on(input int x, input int y);
        int k, c, r, dig;
        if (x < ox || x >= ox + N * W || y < oy || y >= oy + H) return 1'b0;
        k   = (x - ox) / W;
        c   = (x - ox) % W;
        r   = y - oy;
        dig = (shown_m / pow10(N - 1 - k)) % 10;
        if (k < N - 1 && shown_m < pow10(N - 1 - k)) return 1'b0;
        if (!visible_m()) return 1'b0;
        return FONT[dig][r][7 - c];
    endfunction

    task automatic wait_ready();
        int cnt = 0;
        while (!add_ready && cnt < 50) begin
            tick();
            cnt++;
        end
        check("ready_wait", 32'(add_ready), 32'd1);
    endtask

    task automatic add_one(input int v);
        int  cnt, vc, visits, p;
        bit  go;
        wait_ready();
        add_valid = 1'b1;
        add_value = 4'(v);
        tick();
        add_valid = 1'b0;
        vc     = (v > 9) ? 9 : v;
        visits = 1;
        go     = 1'b1;
        for (int i = 0; i < N - 1; i++) begin
            p = pow10(i + 1);
            if (go && (score_m % p) + vc >= p) visits++;
            else go = 1'b0;
        end
        cnt = 0;
        while (!add_ready && cnt < 50) begin
            cnt++;
            tick();
        end
        check($sformatf("busy_cycles(+%0d)", v), 32'(cnt), 32'(visits + 1));
        score_m = score_m + vc;
        if (score_m >= pow10(N)) begin
            score_m = pow10(N) - 1;
            sat_m   = 1'b1;
        end
        check("score", 32'(score_bcd), to_bcd(score_m));
        check("saturated", 32'(saturated), 32'(sat_m));
    endtask

    task automatic pulse_frame();
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        shown_m = score_m;
        if (sat_m) sat_frames++;
        else       sat_frames = 0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        score_m = 0;
        sat_m = 1'b0;
        sat_frames = 0;
        check("clear_score", 32'(score_bcd), 32'd0);
        check("clear_sat", 32'(saturated), 32'd0);
        check("clear_ready", 32'(add_ready), 32'd1);
    endtask

    task automatic set_origin(input int x, input int y);
        ox = x;
        oy = y;
        xcoord_ini = 10'(x);
        ycoord_ini = 10'(y);
    endtask

    task automatic check_pix(input pix_t p);
        check($sformatf("on@%0d,%0d", p.x, p.y), 32'(on), 32'(p.e));
        check($sformatf("rgb@%0d,%0d", p.x, p.y), 32'(rgb), p.e ? 32'd7 : 32'd0);
    endtask

    // Output seen after each tick belongs to the pixel driven one tick earlier.
    task automatic scan(input int x_lo, input int x_hi, input int y_lo, input int y_hi);
        pix_t q[$];
        pix_t p;
        for (int y = y_lo; y <= y_hi; y++) begin
            for (int x = x_lo; x <= x_hi; x++) begin
                pixel_x = 10'(x);
                pixel_y = 10'(y);
                p.x = x;
                p.y = y;
                p.e = model_on(x, y);
                q.push_back(p);
                tick();
                if (q.size() >= 2) check_pix(q.pop_front());
            end
        end
        tick();
        check_pix(q.pop_front());
    endtask

    initial begin
        int hs, cnt;
        rst = 1'b1; frame_tick = 1'b0; clear = 1'b0; add_valid = 1'b0; add_value = 4'd0;
        pixel_x = '0; pixel_y = '0;
        score_m = 0; shown_m = 0; sat_m = 1'b0; sat_frames = 0;
        set_origin(40, 40);
        tick();
        check("rst_on", 32'(on), 32'd0);
        check("rst_rgb", 32'(rgb), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("rst_score", 32'(score_bcd), 32'd0);
        check("rst_sat", 32'(saturated), 32'd0);
        check("rst_ready", 32'(add_ready), 32'd1);

        // Zero score: only the units glyph is drawn
        scan(38, 40 + N * W + 1, 39, 40 + H);

        // 9 + 1 ripples into the tens; shown holds until the next frame
        add_one(9);
        pulse_frame();
        add_one(1);
        scan(40 + (N - 2) * W, 40 + N * W - 1, 40, 40 + H - 1);
        pulse_frame();
        scan(40 + (N - 2) * W, 40 + N * W - 1, 40, 40 + H - 1);

        // Random amounts (values above 9 clamp) and random origins
        repeat (40) add_one(int'($urandom_range(0, 15)));
        pulse_frame();
        repeat (3) begin
            set_origin(int'($urandom_range(2, 980)), int'($urandom_range(1, 460)));
            scan(ox - 2, ox + N * W + 1, oy - 1, oy + H);
        end

        // clear lands in the ADD cycle of 0999 + 1
        do_clear();
        while (score_m + 9 <= 999) add_one(9);
        add_one(999 - score_m);
        wait_ready();
        add_valid = 1'b1;
        add_value = 4'd1;
        tick();
        add_valid = 1'b0;
        check("in_add", 32'(add_ready), 32'd0);
        do_clear();
        repeat (4) tick();
        check("dropped_add_score", 32'(score_bcd), 32'd0);
        check("dropped_add_ready", 32'(add_ready), 32'd1);

        // clear with add_valid in the same cycle: add is not accepted
        add_one(5);
        clear = 1'b1;
        add_valid = 1'b1;
        add_value = 4'd4;
        tick();
        clear = 1'b0;
        add_valid = 1'b0;
        score_m = 0;
        check("clr_vs_add_ready", 32'(add_ready), 32'd1);
        repeat (3) tick();
        check("clr_vs_add_score", 32'(score_bcd), 32'd0);

        // Held valid: five back-to-back handshakes of 3
        hs = 0;
        cnt = 0;
        add_valid = 1'b1;
        add_value = 4'd3;
        while (hs < 5 && cnt < 100) begin
            if (add_ready) begin
                check($sformatf("b2b_score%0d", hs), 32'(score_bcd), to_bcd(3 * hs));
                hs++;
            end
            tick();
            cnt++;
        end
        add_valid = 1'b0;
        check("b2b_handshakes", 32'(hs), 32'd5);
        wait_ready();
        score_m = 15;
        check("b2b_final", 32'(score_bcd), to_bcd(15));

        // Climb to 9995, then draw clipped at the right screen edge
        while (score_m + 9 <= 9995) add_one(9);
        add_one(9995 - score_m);
        pulse_frame();
        set_origin(1010, 470);
        scan(1004, 1023, 469, 482);
        scan(0, 40, 469, 482);

        // Overflow clamps to 9999 and blinks every BLINK frames
        add_one(7);
        pulse_frame();
        set_origin(40, 40);
        scan(40, 40 + N * W - 1, 40, 40 + H - 1);
        repeat (14) pulse_frame();
        scan(40, 40 + N * W - 1, 41, 41);
        pulse_frame();
        scan(40, 40 + N * W - 1, 41, 41);
        repeat (16) pulse_frame();
        scan(40, 40 + N * W - 1, 40, 44);
        do_clear();

        // Reset while a lit pixel is in the pipeline
        pixel_x = 10'd42;
        pixel_y = 10'd41;
        tick();
        tick();
        check("lit_before_rst", 32'(on), 32'(model_on(42, 41)));
        rst = 1'b1;
        tick();
        check("rst_mid_on", 32'(on), 32'd0);
        check("rst_mid_rgb", 32'(rgb), 32'd0);
        rst = 1'b0;
        tick();
        check("rst_mid_score", 32'(score_bcd), 32'd0);
        check("rst_mid_ready", 32'(add_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
